// File: rtl/hb_master_arbiter.sv
`default_nettype none
// ============================================================================
// hb_master_arbiter : round-robin arbiter sharing one XT_HBUS slave port
//                     between several masters, with a transaction watchdog.
// Revision 1.0
// ============================================================================
module hb_master_arbiter #(
   parameter int MASTER_NUM = 3,
   parameter int TIMEOUT    = 15
) (
   input  logic                     hb_clk,
   input  logic                     rst,
   input  logic [MASTER_NUM-1:0]    m_ren,
   input  logic [MASTER_NUM-1:0]    m_wen,
   input  logic [MASTER_NUM*32-1:0] m_raddr,
   input  logic [MASTER_NUM*32-1:0] m_waddr,
   input  logic [MASTER_NUM*32-1:0] m_wdata,
   output logic [MASTER_NUM-1:0]    m_grant,
   output logic [MASTER_NUM-1:0]    m_rdone,
   output logic [MASTER_NUM-1:0]    m_wdone,
   output logic [31:0]              m_rdata,
   output logic                     s_ren,
   output logic                     s_wen,
   output logic [31:0]              s_raddr,
   output logic [31:0]              s_waddr,
   output logic [31:0]              s_wdata,
   input  logic                     s_read_finish,
   input  logic                     s_write_finish,
   input  logic [31:0]              s_rdata,
   output logic                     err_timeout
);

   localparam int                     C_IDX_W   = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
   localparam logic [MASTER_NUM-1:0]  C_ONE     = {{(MASTER_NUM-1){1'b0}}, 1'b1};
   localparam logic [C_IDX_W-1:0]     C_IDX_MAX = C_IDX_W'(MASTER_NUM - 1);
   localparam logic [7:0]             C_TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [C_IDX_W-1:0]    r_ptr;
   logic [C_IDX_W-1:0]    r_owner;
   logic [MASTER_NUM-1:0] r_mask;
   logic [7:0]            r_cnt;

   logic [MASTER_NUM-1:0] w_req;
   logic                  w_hi_found;
   logic                  w_lo_found;
   logic [C_IDX_W-1:0]    w_hi_idx;
   logic [C_IDX_W-1:0]    w_lo_idx;
   logic [C_IDX_W-1:0]    w_win_idx;
   logic [MASTER_NUM-1:0] w_win_onehot;
   logic                  w_start;
   logic                  w_start_wr;
   logic                  w_finish;
   logic                  w_abort;
   logic                  w_end;

   logic [31:0] w_raddr_arr [MASTER_NUM];
   logic [31:0] w_waddr_arr [MASTER_NUM];
   logic [31:0] w_wdata_arr [MASTER_NUM];

   for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_unpack
      assign w_raddr_arr[gi] = m_raddr[gi*32 +: 32];
      assign w_waddr_arr[gi] = m_waddr[gi*32 +: 32];
      assign w_wdata_arr[gi] = m_wdata[gi*32 +: 32];
   end

   // The master that just completed sits out one arbitration so it can drop its request.
   assign w_req = (m_ren | m_wen) & ~r_mask;

   // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
   always_comb begin
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_lo_found = 1'b1;
            w_lo_idx   = C_IDX_W'(i);
            if (C_IDX_W'(i) >= r_ptr) begin
               w_hi_found = 1'b1;
               w_hi_idx   = C_IDX_W'(i);
            end
         end
      end
   end

   assign w_win_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
   assign w_win_onehot = C_ONE << w_win_idx;

   always_ff @(posedge hb_clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_start_wr  = 1'b0;
      w_finish    = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_lo_found) begin
               w_start     = 1'b1;
               w_start_wr  = m_wen[w_win_idx];
               w_state_nxt = w_start_wr ? ST_WRITE : ST_READ;
            end
         end
         ST_READ: begin
            if (s_read_finish) begin
               w_finish = 1'b1;
            end else if (r_cnt == C_TO_LAST) begin
               w_abort = 1'b1;
            end
            if (w_finish || w_abort) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (s_write_finish) begin
               w_finish = 1'b1;
            end else if (r_cnt == C_TO_LAST) begin
               w_abort = 1'b1;
            end
            if (w_finish || w_abort) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_end = w_finish | w_abort;

   always_ff @(posedge hb_clk or posedge rst) begin
      if (rst) begin
         r_ptr       <= '0;
         r_owner     <= '0;
         r_mask      <= '0;
         r_cnt       <= '0;
         m_grant     <= '0;
         m_rdone     <= '0;
         m_wdone     <= '0;
         m_rdata     <= '0;
         s_ren       <= 1'b0;
         s_wen       <= 1'b0;
         s_raddr     <= '0;
         s_waddr     <= '0;
         s_wdata     <= '0;
         err_timeout <= 1'b0;
      end else begin
         m_rdone     <= '0;
         m_wdone     <= '0;
         err_timeout <= 1'b0;
         r_mask      <= '0;

         if (w_start) begin
            r_owner <= w_win_idx;
            m_grant <= w_win_onehot;
            s_raddr <= w_raddr_arr[w_win_idx];
            s_waddr <= w_waddr_arr[w_win_idx];
            s_wdata <= w_wdata_arr[w_win_idx];
            s_wen   <= w_start_wr;
            s_ren   <= ~w_start_wr;
            r_cnt   <= '0;
         end else if (r_state != ST_IDLE) begin
            r_cnt <= r_cnt + 8'd1;
         end

         if (w_end) begin
            s_ren       <= 1'b0;
            s_wen       <= 1'b0;
            m_grant     <= '0;
            r_mask      <= m_grant;
            r_ptr       <= (r_owner == C_IDX_MAX) ? '0 : r_owner + 1'b1;
            err_timeout <= w_abort;
            if (r_state == ST_READ) begin
               m_rdone <= m_grant;
               m_rdata <= w_finish ? s_rdata : 32'hFFFF_FFFF;
            end else begin
               m_wdone <= m_grant;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/hb_master_arbiter.md
Name: hb_master_arbiter

Overview:
- Round-robin arbiter sharing the single XT_HBUS slave port of the system peripheral block between several bus masters: CPU data port, DMA engine and debug/boot loader.
- Serialises one transaction at a time and forwards it to the slave.
- Holds the slave strobe until the slave's finish handshake, then returns a one-cycle done pulse and read data to the owning master.
- A watchdog aborts transactions whose slave never finishes.

Parameters:
- MASTER_NUM, 3, number of requesting masters (2..8); index 0 has the highest priority after reset.
- TIMEOUT, 15, maximum cycles a transaction may wait for the slave's finish before abort (1..255).

Ports:
- hb_clk  in  1  bus clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- m_ren  in  MASTER_NUM  per-master read request; level, held until m_rdone.
- m_wen  in  MASTER_NUM  per-master write request; level, held until m_wdone.
- m_raddr  in  MASTER_NUM*32  flattened per-master read addresses; master i uses bits [32i+31:32i].
- m_waddr  in  MASTER_NUM*32  flattened per-master write addresses.
- m_wdata  in  MASTER_NUM*32  flattened per-master write data.
- m_grant  out  MASTER_NUM  one-hot; indicates the current bus owner.
- m_rdone  out  MASTER_NUM  one-cycle read-complete pulse to the owner.
- m_wdone  out  MASTER_NUM  one-cycle write-complete pulse to the owner.
- m_rdata  out  32  read data, broadcast to all masters; valid only in the cycle of m_rdone.
- s_ren  out  1  slave read enable.
- s_wen  out  1  slave write enable.
- s_raddr  out  32  slave read address.
- s_waddr  out  32  slave write address.
- s_wdata  out  32  slave write data.
- s_read_finish  in  1  slave read-complete handshake.
- s_write_finish  in  1  slave write-complete handshake.
- s_rdata  in  32  slave read data.
- err_timeout  out  1  one-cycle pulse when a transaction is aborted.

Behaviour:
- Reset values (asynchronous): state=IDLE, all outputs 0, priority pointer=0, last owner=none, timeout counter=0.
- FSM states are IDLE, READ and WRITE.
- IDLE arbitration:
  - A master requests when m_ren[i] or m_wen[i] is set.
  - The winner is the first requester scanning upward from the pointer, wrapping modulo MASTER_NUM.
  - The master that completed in the previous cycle is masked for one cycle so it can drop its request.
  - Winner has m_wen set: go to WRITE. Only m_ren set: go to READ. Both set: WRITE is served first, and the read is served at a later grant.
  - At the winning edge, register the winner's address/data into s_raddr/s_waddr/s_wdata, set the one-hot m_grant, and assert s_ren or s_wen from the next cycle.
- Addresses and data are frozen for the whole transaction; master input changes are ignored until done.
- READ state:
  - Hold s_ren=1 until s_read_finish=1 is sampled.
  - In that same edge, capture s_rdata into m_rdata, pulse m_rdone[owner] in the following cycle, drop s_ren and m_grant, and return to IDLE.
- WRITE state: identical, using s_wen, s_write_finish and m_wdone. A write finish that is asserted in the first cycle of s_wen completes the write in that cycle.
- Pointer update: on completion, the pointer becomes owner+1 mod MASTER_NUM.
- Timeout:
  - The counter clears on grant and increments each cycle in READ/WRITE.
  - When the counter reaches TIMEOUT with no finish: drop the strobe, pulse the done of the matching type, drive m_rdata=32'hFFFF_FFFF for reads, pulse err_timeout, update the pointer and return to IDLE.
  - If finish and timeout occur on the same edge, finish wins and err_timeout is not pulsed.
- Latency:
  - Request seen at edge k gives s_ren=1 in cycle k+1.
  - With the slave finishing one cycle after ren, m_rdone pulses in cycle k+3.
  - A single-cycle write gives m_wdone in cycle k+2.
- A master dropping its request mid-transaction does not abort the transaction; the done pulse is still issued.
- Reset asserted mid-transaction immediately clears all strobes, grants and dones; no done pulse is issued for the killed transaction.
- s_ren and s_wen are never both 1. At most one bit of m_grant/m_rdone/m_wdone is set at any time.

Test Plan:
- Single master 1 reads addr 0x40, slave returns 0xDEADBEEF one cycle after s_ren -> s_raddr=0x40, m_rdone[1] exactly 3 cycles after request, m_rdata=0xDEADBEEF, other dones 0.
- Masters 0, 1 and 2 all hold writes continuously -> grants occur in order 0,1,2,0,1,2, each m_wdone one pulse, s_wdata matches each owner's data.
- Master 0 asserts both ren and wen -> write completes first, read granted only after masters 1/2 (if requesting) per round-robin; never s_ren&s_wen.
- Slave never finishes read from master 2 -> after 15 cycles err_timeout=1, m_rdone[2]=1, m_rdata=0xFFFFFFFF, next request granted normally.
- Finish and timeout coincide on cycle 15 -> normal completion with slave data, err_timeout stays 0.
- rst pulsed while in READ -> outputs 0 asynchronously, no m_rdone, pointer back to 0; master 0 wins the next simultaneous request.
